// File: rtl/bbox_extract_if.sv
`default_nettype none
// ============================================================================
// Module   : bbox_extract_if
// Brief    : Video-in / bounding-box-out bundle for bbox_extract.
// Revision : 1.0
// ============================================================================
interface bbox_extract_if;
  logic        i_hs;
  logic        i_vs;
  logic        i_de;
  logic        i_bin;
  logic        o_hs;
  logic [11:0] hcount_l;
  logic [11:0] hcount_r;
  logic [11:0] vcount_l;
  logic [11:0] vcount_r;
  logic        o_valid;
  logic        o_empty;

  modport slave (
    input  i_hs, i_vs, i_de, i_bin,
    output o_hs, hcount_l, hcount_r, vcount_l, vcount_r, o_valid, o_empty
  );

  modport master (
    output i_hs, i_vs, i_de, i_bin,
    input  o_hs, hcount_l, hcount_r, vcount_l, vcount_r, o_valid, o_empty
  );
endinterface
`default_nettype wire

// File: rtl/bbox_extract.sv
`default_nettype none
// ============================================================================
// Module   : bbox_extract
// Brief    : Per-frame bounding box of foreground pixels in a binarised stream.
// Revision : 1.0
// ============================================================================
module bbox_extract #(
  parameter int MIN_COUNT = 16
) (
  input  logic          pixelclk,
  input  logic          rst,
  bbox_extract_if.slave vid
);
  localparam logic [0:0]  C_ST_ARM    = 1'b0;
  localparam logic [0:0]  C_ST_ACTIVE = 1'b1;
  localparam logic [11:0] C_CMAX      = 12'hFFF;
  localparam logic [21:0] C_CNT_MAX   = 22'h3FFFFF;
  localparam logic [21:0] C_MIN       = 22'(MIN_COUNT);

  logic [0:0]  state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        de_q, vs_q;
  logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [11:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [21:0] cnt_q, cnt_d;
  logic [11:0] hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
  logic        valid_q, valid_d, empty_q, empty_d;
  logic        vs_rise, de_fall, hit, accum_en, report, non_empty;

  assign vs_rise   = vid.i_vs & ~vs_q;
  assign de_fall   = de_q & ~vid.i_de;
  assign hit       = vid.i_de & vid.i_bin;
  // A zero count never reports the cleared extremes, even with MIN_COUNT=0.
  assign non_empty = (cnt_q != '0) && (cnt_q >= C_MIN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pixelclk) begin
    if (rst) state_q <= C_ST_ARM;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_ARM:    if (vs_rise) state_d = C_ST_ACTIVE;
      C_ST_ACTIVE: state_d = C_ST_ACTIVE;
      default:     state_d = C_ST_ARM;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accum_en = 1'b0;
    report   = 1'b0;
    if (state_q == C_ST_ACTIVE) begin
      accum_en = hit & ~vs_rise;
      report   = vs_rise;
    end
  end

  // ---------------- pixel coordinates ----------------
  always_comb begin
    x_d = '0;
    if (vid.i_de) x_d = (x_q == C_CMAX) ? x_q : x_q + 12'd1;

    y_d = y_q;
    if (vs_rise)                      y_d = '0;
    else if (de_fall && y_q != C_CMAX) y_d = y_q + 12'd1;
  end

  // ---------------- accumulators ----------------
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (vs_rise) begin
      xmin_d = C_CMAX;
      xmax_d = '0;
      ymin_d = C_CMAX;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (accum_en) begin
      if (x_q < xmin_q) xmin_d = x_q;
      if (x_q > xmax_q) xmax_d = x_q;
      if (y_q < ymin_q) ymin_d = y_q;
      if (y_q > ymax_q) ymax_d = y_q;
      if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + 22'd1;
    end
  end

  // ---------------- report registers ----------------
  always_comb begin
    hl_d    = hl_q;
    hr_d    = hr_q;
    vl_d    = vl_q;
    vr_d    = vr_q;
    empty_d = empty_q;
    valid_d = report;
    if (report) begin
      hl_d    = non_empty ? xmin_q : '0;
      hr_d    = non_empty ? xmax_q : '0;
      vl_d    = non_empty ? ymin_q : '0;
      vr_d    = non_empty ? ymax_q : '0;
      empty_d = ~non_empty;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      xmin_q  <= C_CMAX;
      xmax_q  <= '0;
      ymin_q  <= C_CMAX;
      ymax_q  <= '0;
      cnt_q   <= '0;
      hl_q    <= '0;
      hr_q    <= '0;
      vl_q    <= '0;
      vr_q    <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= vid.i_de;
      vs_q    <= vid.i_vs;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cnt_q   <= cnt_d;
      hl_q    <= hl_d;
      hr_q    <= hr_d;
      vl_q    <= vl_d;
      vr_q    <= vr_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
    end
  end

  assign vid.o_hs     = vid.i_hs;
  assign vid.hcount_l = hl_q;
  assign vid.hcount_r = hr_q;
  assign vid.vcount_l = vl_q;
  assign vid.vcount_r = vr_q;
  assign vid.o_valid  = valid_q;
  assign vid.o_empty  = empty_q;

endmodule
`default_nettype wire
